// File: rtl/mpb_pkg.sv
// Constants and state type shared by the program loader, the microprocessor
// and their benches.
package mpb_pkg;

  localparam int         ADDR_W      = 10;
  localparam int         DEPTH       = 1024;
  localparam logic [7:0] HALT_OPCODE = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_TERM  = 3'd3,
    S_ARM   = 3'd4,
    S_RUN   = 3'd5,
    S_DONE  = 3'd6
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Streams a program into the program RAM, appends the HALT sentinel, then
// enables the microprocessor and captures its result when it stops.
module program_loader
  import mpb_pkg::*;
#(
  parameter int ARM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_enable,
  input  logic              cpu_running,
  input  logic [7:0]        cpu_result,
  input  logic              restart,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   load_count,
  output logic [7:0]        result_q
);

  localparam int                TMR_W    = $clog2(ARM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(ARM_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
  localparam logic [ADDR_W:0]   CAPACITY = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [TMR_W-1:0]  r_tmr;
  logic              w_accept;
  logic [ADDR_W:0]   w_cnt_inc;

  assign s_ready   = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign w_accept  = s_valid & s_ready;
  assign w_cnt_inc = load_count + CNT_ONE;

  // Loader FSM with its pointer, byte count, arm timeout and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= {ADDR_W{1'b0}};
      r_tmr      <= {TMR_W{1'b0}};
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= 8'h00;
      cpu_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      load_count <= {(ADDR_W + 1){1'b0}};
      result_q   <= 8'h00;
    end else begin
      mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            mem_we     <= 1'b1;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_wdata  <= s_data;
            r_wr_ptr   <= PTR_ONE;
            load_count <= CNT_ONE;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            r_state    <= s_last ? S_TERM : S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            mem_we     <= 1'b1;
            mem_addr   <= r_wr_ptr;
            mem_wdata  <= s_data;
            r_wr_ptr   <= r_wr_ptr + PTR_ONE;
            load_count <= w_cnt_inc;
            // The last RAM slot is reserved for the sentinel.
            if (s_last) begin
              r_state <= S_TERM;
            end else if (w_cnt_inc == CAPACITY) begin
              overflow <= 1'b1;
              r_state  <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_accept && s_last) begin
            r_state <= S_TERM;
          end
        end
        S_TERM: begin
          mem_we     <= 1'b1;
          mem_addr   <= load_count[ADDR_W-1:0];
          mem_wdata  <= HALT_OPCODE;
          cpu_enable <= 1'b1;
          r_tmr      <= {TMR_W{1'b0}};
          r_state    <= S_ARM;
        end
        S_ARM: begin
          if (cpu_running) begin
            r_state <= S_RUN;
          end else if (r_tmr == TMR_LAST) begin
            result_q   <= cpu_result;
            cpu_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_tmr <= r_tmr + TMR_ONE;
          end
        end
        S_RUN: begin
          if (!cpu_running) begin
            result_q   <= cpu_result;
            cpu_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (restart) begin
            done    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          cpu_enable <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed/randomized bench for program_loader against a stream-level model of
// which bytes should land where in program RAM.
module tb_program_loader;
  import mpb_pkg::*;

  localparam int ARM_TIMEOUT = 16;
  localparam int CAP         = DEPTH - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_enable;
  logic              cpu_running;
  logic [7:0]        cpu_result;
  logic              restart;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   load_count;
  logic [7:0]        result_q;

  program_loader #(.ARM_TIMEOUT(ARM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_enable(cpu_enable), .cpu_running(cpu_running), .cpu_result(cpu_result),
    .restart(restart), .busy(busy), .done(done), .overflow(overflow),
    .load_count(load_count), .result_q(result_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] dq[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  // Record every RAM write seen by the microprocessor's program memory.
  always @(negedge clk) begin
    if (rst_n && mem_we) wr_q.push_back('{int'(mem_addr), int'(mem_wdata)});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive dq as a stream; caller is positioned just after a negedge.
  task automatic send(input bit gaps, input bit with_last);
    int not_ready = 0;
    for (int i = 0; i < dq.size(); i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = dq[i];
      s_last  = with_last && (i == dq.size() - 1);
      if (s_ready !== 1'b1) not_ready++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("s_ready_during_stream", not_ready, 0);
  endtask

  // Expected RAM image: up to DEPTH-1 program bytes, then HALT right after them.
  task automatic check_writes(input string tag);
    wr_t exp_q[$];
    int  n    = (dq.size() > CAP) ? CAP : dq.size();
    int  bad  = 0;
    int  lim;
    for (int i = 0; i < n; i++) exp_q.push_back('{i, int'(dq[i])});
    exp_q.push_back('{n, int'(HALT_OPCODE)});
    chk({tag, "_nwrites"}, wr_q.size(), exp_q.size());
    lim = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      if (wr_q[i].addr != exp_q[i].addr || wr_q[i].data != exp_q[i].data) bad++;
    end
    chk({tag, "_bad_writes"}, bad, 0);
    chk({tag, "_load_count"}, load_count, n);
    chk({tag, "_overflow"}, overflow, (dq.size() > CAP) ? 1 : 0);
  endtask

  task automatic fill_random(input int n);
    dq.delete();
    for (int i = 0; i < n; i++) dq.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    int         k;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    cpu_running = 1'b0; cpu_result = 8'h00; restart = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cpu_enable", cpu_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_result_q", result_q, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: three-byte program
    dq = '{8'h12, 8'h34, 8'h56};
    wr_q.delete();
    send(1'b0, 1'b1);
    chk("t1_enable_in_term", cpu_enable, 0);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_enable_after_term", cpu_enable, 1);
    chk("t1_s_ready_arm", s_ready, 0);
    @(negedge clk);
    check_writes("t1");

    // 2: run, restart ignored while running, result capture
    cpu_running = 1'b1;
    repeat (2) @(negedge clk);
    pulse_restart();
    chk("t2_restart_ignored_busy", busy, 1);
    chk("t2_restart_ignored_done", done, 0);
    repeat (2) @(negedge clk);
    cpu_result  = 8'hA5;
    cpu_running = 1'b0;
    @(negedge clk);
    chk("t2_result_q", result_q, 8'hA5);
    chk("t2_done", done, 1);
    chk("t2_cpu_enable", cpu_enable, 0);
    chk("t2_busy", busy, 0);
    chk("t2_s_ready_done", s_ready, 0);
    pulse_restart();
    chk("t2_s_ready_idle", s_ready, 1);
    chk("t2_done_cleared", done, 0);

    // 3 + 5: overflowing program, then ARM timeout
    fill_random(1030);
    wr_q.delete();
    r = 8'($urandom_range(0, 255));
    cpu_result = r;
    send(1'b0, 1'b1);
    @(negedge clk);
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t5_timeout_cycles", k, ARM_TIMEOUT);
    chk("t5_result_q", result_q, r);
    chk("t5_cpu_enable", cpu_enable, 0);
    check_writes("t3");
    pulse_restart();

    // 4: five-byte program with random valid gaps
    fill_random(5);
    wr_q.delete();
    send(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check_writes("t4");
    cpu_running = 1'b1;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    r = 8'($urandom_range(0, 255));
    cpu_result  = r;
    cpu_running = 1'b0;
    @(negedge clk);
    chk("t4_result_q", result_q, r);
    chk("t4_done", done, 1);
    pulse_restart();

    // 6: async reset during LOAD, then during RUN
    fill_random(3);
    send(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6a_busy", busy, 0);
    chk("t6a_load_count", load_count, 0);
    chk("t6a_mem_we", mem_we, 0);
    chk("t6a_s_ready", s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_random(2);
    wr_q.delete();
    send(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check_writes("t6b");
    cpu_running = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6c_enable_in_run", cpu_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6c_cpu_enable", cpu_enable, 0);
    chk("t6c_busy", busy, 0);
    chk("t6c_done", done, 0);
    chk("t6c_result_q", result_q, 0);
    chk("t6c_mem_addr", mem_addr, 0);
    cpu_running = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_random(1);
    wr_q.delete();
    send(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check_writes("t6d");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
